// File: rtl/uart_wb_pkg.sv
// Shared types and constants for the UART-to-Wishbone debug master:
// command opcodes, response bytes and controller states.
package uart_wb_pkg;

    typedef enum logic [1:0] {
        OP_SETADDR = 2'b00,
        OP_WRITE   = 2'b01,
        OP_READ    = 2'b10,
        OP_NOP     = 2'b11
    } opcode_t;

    localparam logic [7:0] RSP_ADDR = 8'h41;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_READ = 8'h52;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_TMO  = 8'h54;
    localparam logic [7:0] RSP_NOP  = 8'h4E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS_REQ,
        ST_BUS_WAIT,
        ST_TX_LOAD,
        ST_TX_WAIT
    } state_t;

    // Responses are left-aligned in a 40-bit buffer and sent MSB first.
    function automatic logic [39:0] single_rsp(input logic [7:0] b);
        return {b, 32'h0000_0000};
    endfunction

endpackage

// File: rtl/uart_resp_ser.sv
// Response serializer: takes up to five bytes plus a count and hands them
// one at a time to the UART transmitter, pacing on its busy flag.
module uart_resp_ser
    import uart_wb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [39:0] i_bytes,
    input  logic [2:0]  i_count,
    input  logic        i_tx_busy,
    output logic        o_tx_stb,
    output logic [7:0]  o_tx_byte,
    output logic        o_done
);

    state_t      state_q, state_d;
    logic [39:0] bytes_q, bytes_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        first_q, first_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            bytes_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // The first TX_WAIT cycle ignores busy so the transmitter has time to raise it.
    always_comb begin
        state_d = state_q;
        bytes_d = bytes_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    bytes_d = i_bytes;
                    cnt_d   = i_count;
                    state_d = ST_TX_LOAD;
                end
            end
            ST_TX_LOAD: begin
                if (!i_tx_busy) begin
                    bytes_d = {bytes_q[31:0], 8'h00};
                    cnt_d   = cnt_q - 1'b1;
                    first_d = 1'b1;
                    state_d = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!i_tx_busy) begin
                    state_d = (cnt_q != 3'd0) ? ST_TX_LOAD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_tx_stb  = (state_q == ST_TX_LOAD) && !i_tx_busy;
        o_tx_byte = bytes_q[39:32];
        o_done    = (state_q == ST_TX_WAIT) && !first_q && !i_tx_busy && (cnt_q == 3'd0);
    end

endmodule

// File: rtl/uart_wb_master.sv
// Wishbone bus master driven by decoded UART commands; returns a response
// byte stream. Define UART_WB_TIMEOUT_EN to abort stuck bus cycles.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_stb,
    input  logic [33:0]   i_cmd_word,
    output logic          o_cmd_busy,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_tx_stb,
    output logic [7:0]    o_tx_byte,
    input  logic          i_tx_busy
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_q, we_d;
    logic          ser_load;
    logic [39:0]   ser_bytes;
    logic [2:0]    ser_cnt;
    logic          ser_done;
    logic          timeout;
    logic          bus_live;
    opcode_t       cmd_op;

    assign cmd_op = opcode_t'(i_cmd_word[33:32]);
    // A response from the slave only counts once the strobe has been accepted.
    assign bus_live = (state_q == ST_BUS_WAIT) || ((state_q == ST_BUS_REQ) && !i_wb_stall);

`ifdef UART_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else if ((state_q == ST_BUS_REQ) || (state_q == ST_BUS_WAIT)) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end

    assign timeout = ((state_q == ST_BUS_REQ) || (state_q == ST_BUS_WAIT)) &&
                     (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        ser_load  = 1'b0;
        ser_bytes = '0;
        ser_cnt   = 3'd1;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_stb) begin
                    case (cmd_op)
                        OP_SETADDR: begin
                            addr_d    = i_cmd_word[AW-1:0];
                            ser_load  = 1'b1;
                            ser_bytes = single_rsp(RSP_ADDR);
                            state_d   = ST_TX_LOAD;
                        end
                        OP_NOP: begin
                            ser_load  = 1'b1;
                            ser_bytes = single_rsp(RSP_NOP);
                            state_d   = ST_TX_LOAD;
                        end
                        default: begin
                            data_d  = i_cmd_word[DW-1:0];
                            we_d    = (cmd_op == OP_WRITE);
                            state_d = ST_BUS_REQ;
                        end
                    endcase
                end
            end
            ST_BUS_REQ, ST_BUS_WAIT: begin
                if (bus_live && i_wb_err) begin
                    ser_load  = 1'b1;
                    ser_bytes = single_rsp(RSP_ERR);
                    state_d   = ST_TX_LOAD;
                end else if (bus_live && i_wb_ack) begin
                    addr_d   = addr_q + 1'b1;
                    ser_load = 1'b1;
                    if (we_q) begin
                        ser_bytes = single_rsp(RSP_OK);
                    end else begin
                        ser_bytes = {RSP_READ, i_wb_data};
                        ser_cnt   = 3'd5;
                    end
                    state_d = ST_TX_LOAD;
                end else if (timeout) begin
                    ser_load  = 1'b1;
                    ser_bytes = single_rsp(RSP_TMO);
                    state_d   = ST_TX_LOAD;
                end else if (bus_live) begin
                    state_d = ST_BUS_WAIT;
                end
            end
            ST_TX_LOAD: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_wb_cyc   = (state_q == ST_BUS_REQ) || (state_q == ST_BUS_WAIT);
        o_wb_stb   = (state_q == ST_BUS_REQ);
        o_wb_we    = o_wb_cyc && we_q;
        o_wb_sel   = {4{o_wb_stb}};
        o_wb_addr  = addr_q;
        o_wb_data  = data_q;
        o_cmd_busy = (state_q != ST_IDLE);
    end

    uart_resp_ser u_ser (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (ser_load),
        .i_bytes   (ser_bytes),
        .i_count   (ser_cnt),
        .i_tx_busy (i_tx_busy),
        .o_tx_stb  (o_tx_stb),
        .o_tx_byte (o_tx_byte),
        .o_done    (ser_done)
    );

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed self-checking bench for uart_wb_master with a small UART TX
// responder model; covers the optional UART_WB_TIMEOUT_EN build as well.
module tb_uart_wb_master;

    logic        clk;
    logic        rstN;
    logic        cmdStb;
    logic [33:0] cmdWord;
    logic        cmdBusy;
    logic        wbCyc, wbStb, wbWe;
    logic [31:0] wbAddr, wbDataOut, wbDataIn;
    logic [3:0]  wbSel;
    logic        wbStall, wbAck, wbErr;
    logic        txStb;
    logic [7:0]  txByte;
    logic        txBusy;

    int          testsRun;
    int          testsFailed;
    logic [7:0]  txq[$];
    int          busyLeft;
    bit          pend;
    int          cycCycles;

    uart_wb_master #(.AW(32), .DW(32), .TIMEOUT_CYC(15)) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_cmd_stb  (cmdStb),
        .i_cmd_word (cmdWord),
        .o_cmd_busy (cmdBusy),
        .o_wb_cyc   (wbCyc),
        .o_wb_stb   (wbStb),
        .o_wb_we    (wbWe),
        .o_wb_addr  (wbAddr),
        .o_wb_data  (wbDataOut),
        .o_wb_sel   (wbSel),
        .i_wb_stall (wbStall),
        .i_wb_ack   (wbAck),
        .i_wb_err   (wbErr),
        .i_wb_data  (wbDataIn),
        .o_tx_stb   (txStb),
        .o_tx_byte  (txByte),
        .i_tx_busy  (txBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART TX model: busy rises the cycle after a strobe and stays up three cycles.
    initial begin
        bit sawStb;
        txBusy   = 1'b0;
        busyLeft = 0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            sawStb = txStb;
            if (!rstN) begin
                pend     = 1'b0;
                busyLeft = 0;
                txBusy   = 1'b0;
            end else begin
                if (busyLeft > 0) begin
                    busyLeft--;
                    if (busyLeft == 0) txBusy = 1'b0;
                end else if (pend) begin
                    txBusy   = 1'b1;
                    busyLeft = 3;
                    pend     = 1'b0;
                end
                if (sawStb) begin
                    txq.push_back(txByte);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        cycCycles = 0;
        forever begin
            @(negedge clk);
            if (wbCyc) cycCycles++;
        end
    end

    function automatic logic [39:0] packTx();
        logic [39:0] v;
        v = '0;
        foreach (txq[i]) v = {v[31:0], txq[i]};
        return v;
    endfunction

    task automatic sendCmd(input logic [1:0] op, input logic [31:0] payload);
        cmdStb  = 1'b1;
        cmdWord = {op, payload};
        @(negedge clk);
        cmdStb  = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((cmdBusy || txBusy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (n >= 300) begin
            testsFailed++;
            $display("[TB] FAIL %s_idle: still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if ({wbCyc, wbStb, wbWe, txStb, cmdBusy} !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b required 00000", {wbCyc, wbStb, wbWe, txStb, cmdBusy});
        end
        testsRun++;
        if (wbAddr !== 32'h0 || wbSel !== 4'h0 || txByte !== 8'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: addr %h sel %h byte %h required all 0", wbAddr, wbSel, txByte);
        end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_setaddr_read();
        txq.delete();
        cycCycles = 0;
        sendCmd(2'b00, 32'h0000_0010);
        waitIdle("setaddr");
        testsRun++;
        if (txq.size() != 1 || packTx() !== 40'h41) begin
            testsFailed++;
            $display("[TB] FAIL setaddr_tx: got %h (n=%0d) required 41", packTx(), txq.size());
        end
        testsRun++;
        if (cycCycles != 0) begin
            testsFailed++;
            $display("[TB] FAIL setaddr_nocyc: cyc high %0d cycles, required 0", cycCycles);
        end
        txq.delete();
        sendCmd(2'b10, 32'h0);
        testsRun++;
        if (!wbStb || !wbCyc || wbWe || wbAddr !== 32'h10 || wbSel !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL read_req: stb %b cyc %b we %b addr %h sel %h required 1 1 0 10 f",
                     wbStb, wbCyc, wbWe, wbAddr, wbSel);
        end
        @(negedge clk);
        testsRun++;
        if (wbStb || !wbCyc) begin
            testsFailed++;
            $display("[TB] FAIL read_wait: stb %b cyc %b required 0 1", wbStb, wbCyc);
        end
        wbAck    = 1'b1;
        wbDataIn = 32'hDEAD_BEEF;
        @(negedge clk);
        wbAck    = 1'b0;
        wbDataIn = 32'h0;
        testsRun++;
        if (!txStb || txByte !== 8'h52 || wbCyc) begin
            testsFailed++;
            $display("[TB] FAIL read_latency: tx_stb %b byte %h cyc %b required 1 52 0", txStb, txByte, wbCyc);
        end
        waitIdle("read");
        testsRun++;
        if (txq.size() != 5 || packTx() !== 40'h52_DEAD_BEEF) begin
            testsFailed++;
            $display("[TB] FAIL read_tx: got %h (n=%0d) required 52deadbeef", packTx(), txq.size());
        end
        testsRun++;
        if (wbAddr !== 32'h11) begin
            testsFailed++;
            $display("[TB] FAIL read_addr_inc: got %h required 11", wbAddr);
        end
    endtask

    task automatic test_write_stall();
        int stbCount;
        txq.delete();
        stbCount = 0;
        wbStall  = 1'b1;
        sendCmd(2'b01, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            if (wbStb) stbCount++;
            testsRun++;
            if (!wbStb || !wbWe || wbAddr !== 32'h11 || wbDataOut !== 32'h1234_5678) begin
                testsFailed++;
                $display("[TB] FAIL write_hold%0d: stb %b we %b addr %h data %h required 1 1 11 12345678",
                         i, wbStb, wbWe, wbAddr, wbDataOut);
            end
            if (i == 3) wbStall = 1'b0;
            @(negedge clk);
        end
        testsRun++;
        if (wbStb || !wbCyc || stbCount != 4) begin
            testsFailed++;
            $display("[TB] FAIL write_accept: stb %b cyc %b count %0d required 0 1 4", wbStb, wbCyc, stbCount);
        end
        wbAck = 1'b1;
        @(negedge clk);
        wbAck = 1'b0;
        waitIdle("write");
        testsRun++;
        if (txq.size() != 1 || packTx() !== 40'h4B) begin
            testsFailed++;
            $display("[TB] FAIL write_tx: got %h (n=%0d) required 4b", packTx(), txq.size());
        end
        testsRun++;
        if (wbAddr !== 32'h12) begin
            testsFailed++;
            $display("[TB] FAIL write_addr_inc: got %h required 12", wbAddr);
        end
    endtask

    task automatic test_err_ack();
        txq.delete();
        sendCmd(2'b10, 32'h0);
        wbAck = 1'b1;
        wbErr = 1'b1;
        @(negedge clk);
        wbAck = 1'b0;
        wbErr = 1'b0;
        testsRun++;
        if (wbCyc || !txStb || txByte !== 8'h45) begin
            testsFailed++;
            $display("[TB] FAIL err_drop: cyc %b tx_stb %b byte %h required 0 1 45", wbCyc, txStb, txByte);
        end
        waitIdle("err");
        testsRun++;
        if (txq.size() != 1 || packTx() !== 40'h45 || wbAddr !== 32'h12) begin
            testsFailed++;
            $display("[TB] FAIL err_tx: got %h (n=%0d) addr %h required 45 addr 12", packTx(), txq.size(), wbAddr);
        end
    endtask

    task automatic test_busy_drop();
        txq.delete();
        cycCycles = 0;
        sendCmd(2'b11, 32'h0);
        testsRun++;
        if (!cmdBusy) begin
            testsFailed++;
            $display("[TB] FAIL nop_busy: got %b required 1", cmdBusy);
        end
        sendCmd(2'b00, 32'h0000_0ABC);
        waitIdle("drop");
        testsRun++;
        if (txq.size() != 1 || packTx() !== 40'h4E || wbAddr !== 32'h12 || cycCycles != 0) begin
            testsFailed++;
            $display("[TB] FAIL busy_drop: tx %h (n=%0d) addr %h cyc %0d required 4e addr 12 cyc 0",
                     packTx(), txq.size(), wbAddr, cycCycles);
        end
    endtask

    task automatic test_timeout();
        int n;
        txq.delete();
        sendCmd(2'b10, 32'h0);
        n = 0;
`ifdef UART_WB_TIMEOUT_EN
        while (wbCyc && n < 60) begin
            n++;
            @(negedge clk);
        end
        testsRun++;
        if (n != 15 || !txStb || txByte !== 8'h54) begin
            testsFailed++;
            $display("[TB] FAIL timeout_drop: cyc cycles %0d tx_stb %b byte %h required 15 1 54", n, txStb, txByte);
        end
        waitIdle("timeout");
        testsRun++;
        if (txq.size() != 1 || packTx() !== 40'h54 || wbAddr !== 32'h12) begin
            testsFailed++;
            $display("[TB] FAIL timeout_tx: got %h (n=%0d) addr %h required 54 addr 12", packTx(), txq.size(), wbAddr);
        end
`else
        while (wbCyc && n < 40) begin
            n++;
            @(negedge clk);
        end
        testsRun++;
        if (n != 40 || txq.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL no_timeout: cyc cycles %0d tx n=%0d required 40 0", n, txq.size());
        end
`endif
    endtask

    task automatic test_async_reset();
        if (!cmdBusy) begin
            sendCmd(2'b10, 32'h0);
            @(negedge clk);
        end
        testsRun++;
        if (!wbCyc || wbStb) begin
            testsFailed++;
            $display("[TB] FAIL areset_pre: cyc %b stb %b required 1 0", wbCyc, wbStb);
        end
        #2 rstN = 1'b0;
        #1;
        testsRun++;
        if (wbCyc || wbStb || txStb || cmdBusy || wbAddr !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL areset_async: cyc %b stb %b tx_stb %b busy %b addr %h required all 0",
                     wbCyc, wbStb, txStb, cmdBusy, wbAddr);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        txq.delete();
        sendCmd(2'b01, 32'hCAFE_F00D);
        testsRun++;
        if (!wbStb || wbAddr !== 32'h0 || wbDataOut !== 32'hCAFE_F00D) begin
            testsFailed++;
            $display("[TB] FAIL areset_write: stb %b addr %h data %h required 1 0 cafef00d", wbStb, wbAddr, wbDataOut);
        end
        wbAck = 1'b1;
        @(negedge clk);
        wbAck = 1'b0;
        waitIdle("areset");
        testsRun++;
        if (txq.size() != 1 || packTx() !== 40'h4B || wbAddr !== 32'h1) begin
            testsFailed++;
            $display("[TB] FAIL areset_resume: tx %h (n=%0d) addr %h required 4b addr 1", packTx(), txq.size(), wbAddr);
        end
    endtask

    initial begin
        rstN        = 1'b0;
        cmdStb      = 1'b0;
        cmdWord     = '0;
        wbStall     = 1'b0;
        wbAck       = 1'b0;
        wbErr       = 1'b0;
        wbDataIn    = '0;
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_setaddr_read();
        test_write_stall();
        test_err_ack();
        test_busy_drop();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
